frame_read_master: RTL and testbench
====================================

FRAME_READ_MASTER -- requirements
Module: frame_read_master

Interface
REQ-001 Parameter NUM_WORDS, default 1024, number of 32-bit words read per frame (32x32 pixels); legal range 1..1024.
REQ-002 Parameter ADDR_W, default 10, width of the word counter; araddr[ADDR_W-1:0] carries the word index.
REQ-003 aclk  in  1  single clock; all state updates on the rising edge.
REQ-004 aresetn  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to read one full frame.
REQ-006 busy  out  1  high from frame acceptance until done.
REQ-007 done  out  1  one-cycle pulse after the last word is accepted downstream.
REQ-008 araddr  out  32  read address; {zeros, word index}.
REQ-009 arvalid  out  1  read-address valid.
REQ-010 arready  in  1  read-address ready from the pixel memory slave.
REQ-011 rdata  in  32  read data from the slave.
REQ-012 rvalid  in  1  read-data valid from the slave.
REQ-013 rready  out  1  read-data ready to the slave.
REQ-014 m_tdata  out  32  pixel word to the CORDIC pipeline.
REQ-015 m_tvalid  out  1  m_tdata valid.
REQ-016 m_tready  in  1  downstream ready.
REQ-017 m_tlast  out  1  high with the word at index NUM_WORDS-1.

Function
REQ-018 FSM states: IDLE, AR, R, OUT, DONE; exactly one active.
REQ-019 IDLE: busy=0; start=1 -> clear index to 0, go to AR.
REQ-020 AR: arvalid=1, araddr=index; araddr held stable until arready=1, then go to R.
REQ-021 R: rready=1; rvalid=1 -> capture rdata into an output register, go to OUT; rvalid in any other state ignored.
REQ-022 OUT: m_tvalid=1; m_tdata and m_tlast stable until m_tready=1.
REQ-023 OUT exit: m_tready=1 with index=NUM_WORDS-1 -> DONE; otherwise index+1, go to AR.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE.
REQ-025 busy=1 in AR, R, OUT and DONE.
REQ-026 start while busy is ignored; no queuing.
REQ-027 arvalid, rready and m_tvalid are never high together; at most one handshake is in progress at a time.
REQ-028 Best-case throughput with arready, rvalid and m_tready tied high: 3 cycles per word; NUM_WORDS words plus the DONE cycle = 3*NUM_WORDS+1 cycles from the first AR cycle to the end of DONE.
REQ-029 The index never wraps past NUM_WORDS-1; araddr upper bits [31:ADDR_W] are always 0.
REQ-030 m_tlast=1 only in OUT with index=NUM_WORDS-1.

Reset
REQ-031 aresetn=0 forces IDLE immediately, regardless of the clock.
REQ-032 During reset: index=0, output data register=0, araddr=0, and arvalid, rready, m_tvalid, m_tlast, busy and done all =0.
REQ-033 Reset mid-frame abandons the frame; no done pulse; after release, the block waits in IDLE for a new start.

Verification
REQ-034 NUM_WORDS=4, slave preloaded mem[i]=0xA0+i, ready/valid always high; pulse start -> m_tdata = 0xA0, 0xA1, 0xA2, 0xA3; m_tlast only on 0xA3; done 13 cycles after the first AR cycle.
REQ-035 arready held low 5 cycles in AR -> araddr=2 and arvalid=1 stable throughout; no rready until the address handshake completes.
REQ-036 m_tready low 7 cycles on word 1 -> m_tdata=0xA1 and m_tvalid held; no new araddr issued; index advances only on the handshake.
REQ-037 start pulsed at word 2 while busy -> ignored; exactly NUM_WORDS words and a single done pulse.
REQ-038 aresetn asserted asynchronously in R at word 3 -> all outputs 0 before the next edge; no done pulse; a new start after release reads from address 0.
REQ-039 NUM_WORDS=1 -> one word with m_tlast=1; done pulses; return to IDLE.

Source files
------------

// File: rtl/frame_read_master.sv
// Frame read master: fetches NUM_WORDS 32-bit pixel words from a memory-mapped
// slave one at a time (address phase, data phase) and forwards each word on a
// valid/ready stream toward the CORDIC pipeline, ending with a one-cycle done.
// Only one handshake is ever open at a time, so a word costs at least 3 cycles.
module frame_read_master #(
  parameter int NUM_WORDS = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_OUT,
    ST_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

  state_t            state;
  logic [ADDR_W-1:0] index;
  logic [31:0]       data_q;

  // The word index doubles as the address; upper address bits stay zero.
  assign araddr  = 32'(index);
  assign m_tdata = data_q;

  // Frame sequencer: every handshake output is registered and set on entry to
  // the state that owns it, so each state presents stable, glitch-free outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= ST_IDLE;
      index    <= '0;
      data_q   <= '0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            index   <= '0;
            arvalid <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_AR;
          end
        end
        ST_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid) begin
            rready   <= 1'b0;
            data_q   <= rdata;
            m_tvalid <= 1'b1;
            m_tlast  <= (index == LAST_IDX);
            state    <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (m_tready) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            if (index == LAST_IDX) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              index   <= index + ADDR_W'(1);
              arvalid <= 1'b1;
              state   <= ST_AR;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          arvalid  <= 1'b0;
          rready   <= 1'b0;
          m_tvalid <= 1'b0;
          m_tlast  <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Design invariants: one handshake open at a time and the index never leaves
  // the frame.
  a_one_handshake: assert property (@(posedge aclk) disable iff (!aresetn)
    $onehot0({arvalid, rready, m_tvalid}));
  a_index_range: assert property (@(posedge aclk) disable iff (!aresetn)
    index <= LAST_IDX);

endmodule

// File: tb/tb_frame_read_master.sv
// Directed bench for frame_read_master: a 4-word instance and a 1-word
// instance, each fed by a tiny slave returning 0xA0 + address.
module tb_frame_read_master;

  logic aclk;
  logic aresetn;

  // 4-word instance
  logic        start4, busy4, done4, arvalid4, arready4, rvalid4, rready4;
  logic        tvalid4, tready4, tlast4;
  logic [31:0] araddr4, rdata4, tdata4;

  // 1-word instance
  logic        start1, busy1, done1, arvalid1, arready1, rvalid1, rready1;
  logic        tvalid1, tready1, tlast1;
  logic [31:0] araddr1, rdata1, tdata1;

  int compared;
  int mismatched;

  assign rdata4 = 32'hA0 + araddr4;
  assign rdata1 = 32'hA0 + araddr1;

  frame_read_master #(.NUM_WORDS(4), .ADDR_W(2)) dut4 (
    .aclk(aclk), .aresetn(aresetn), .start(start4), .busy(busy4), .done(done4),
    .araddr(araddr4), .arvalid(arvalid4), .arready(arready4),
    .rdata(rdata4), .rvalid(rvalid4), .rready(rready4),
    .m_tdata(tdata4), .m_tvalid(tvalid4), .m_tready(tready4), .m_tlast(tlast4)
  );

  frame_read_master #(.NUM_WORDS(1), .ADDR_W(10)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .start(start1), .busy(busy1), .done(done1),
    .araddr(araddr1), .arvalid(arvalid1), .arready(arready1),
    .rdata(rdata1), .rvalid(rvalid1), .rready(rready1),
    .m_tdata(tdata1), .m_tvalid(tvalid1), .m_tready(tready1), .m_tlast(tlast1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done4) seen = 1;
      else step();
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("[TB] FAIL %s_done_timeout: got no done, expected done within 60 cycles", name);
    end
    step();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    start4 = 0; arready4 = 1; rvalid4 = 1; tready4 = 1;
    start1 = 0; arready1 = 1; rvalid1 = 1; tready1 = 1;
    #12;
    compared++;
    if ({busy4, done4, arvalid4, rready4, tvalid4, tlast4} !== 6'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl4: got %b expected 000000",
               {busy4, done4, arvalid4, rready4, tvalid4, tlast4});
    end
    compared++;
    if (araddr4 !== 32'd0 || tdata4 !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_data4: got araddr %h tdata %h expected 0/0", araddr4, tdata4);
    end
    compared++;
    if ({busy1, done1, arvalid1, rready1, tvalid1, tlast1} !== 6'b0 || araddr1 !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_dut1: got ctrl %b araddr %h expected zeros",
               {busy1, done1, arvalid1, rready1, tvalid1, tlast1}, araddr1);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    step();
    step();
    compared++;
    if (busy4 !== 1'b0 || arvalid4 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL idle_after_reset: got busy %b arvalid %b expected 0/0", busy4, arvalid4);
    end
  endtask

  task automatic test_basic_frame();
    int words, dones, done_cyc, overlap, ars;
    arready4 = 1; rvalid4 = 1; tready4 = 1;
    start4 = 1; step(); start4 = 0;
    words = 0; dones = 0; done_cyc = 0; overlap = 0; ars = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc <= 13) begin
        compared++;
        if (busy4 !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL basic_busy cycle %0d: got %b expected 1", cyc, busy4);
        end
      end
      if (arvalid4) begin
        compared++;
        if (araddr4 !== 32'(ars)) begin
          mismatched++;
          $display("[TB] FAIL basic_araddr: got %h expected %h", araddr4, ars);
        end
        ars++;
      end
      if (tvalid4) begin
        compared++;
        if (tdata4 !== 32'(32'hA0 + words)) begin
          mismatched++;
          $display("[TB] FAIL basic_tdata: got %h expected %h", tdata4, 32'hA0 + words);
        end
        compared++;
        if (tlast4 !== (words == 3)) begin
          mismatched++;
          $display("[TB] FAIL basic_tlast word %0d: got %b expected %b", words, tlast4, words == 3);
        end
        words++;
      end else if (tlast4) begin
        overlap++;
      end
      if (done4) begin
        dones++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (int'(arvalid4) + int'(rready4) + int'(tvalid4) > 1) overlap++;
      step();
    end
    compared++;
    if (words != 4 || ars != 4) begin
      mismatched++;
      $display("[TB] FAIL basic_count: got %0d words %0d addrs expected 4/4", words, ars);
    end
    compared++;
    if (dones != 1 || done_cyc != 13) begin
      mismatched++;
      $display("[TB] FAIL basic_done: got %0d pulses at cycle %0d expected 1 at 13", dones, done_cyc);
    end
    compared++;
    if (overlap != 0 || busy4 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_exclusive: got overlap %0d busy %b expected 0/0", overlap, busy4);
    end
  endtask

  task automatic test_ar_stall();
    bit found;
    arready4 = 1; rvalid4 = 1; tready4 = 1;
    start4 = 1; step(); start4 = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (arvalid4 && araddr4 == 32'd2) found = 1;
      else step();
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("[TB] FAIL ar_stall_reach: got no AR for address 2, expected within 20 cycles");
    end
    arready4 = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      compared++;
      if ({arvalid4, rready4, araddr4} !== {1'b1, 1'b0, 32'd2}) begin
        mismatched++;
        $display("[TB] FAIL ar_stall_hold %0d: got arvalid %b rready %b araddr %h expected 1/0/2",
                 i, arvalid4, rready4, araddr4);
      end
    end
    arready4 = 1;
    step();
    compared++;
    if ({arvalid4, rready4, araddr4} !== {1'b0, 1'b1, 32'd2}) begin
      mismatched++;
      $display("[TB] FAIL ar_stall_release: got arvalid %b rready %b araddr %h expected 0/1/2",
               arvalid4, rready4, araddr4);
    end
    wait_done("ar_stall");
  endtask

  task automatic test_tready_stall();
    bit found;
    arready4 = 1; rvalid4 = 1; tready4 = 1;
    start4 = 1; step(); start4 = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (tvalid4 && tdata4 == 32'hA1) found = 1;
      else step();
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("[TB] FAIL tready_stall_reach: got no word 0xA1, expected within 20 cycles");
    end
    tready4 = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      compared++;
      if ({tvalid4, tdata4, arvalid4, araddr4} !== {1'b1, 32'hA1, 1'b0, 32'd1}) begin
        mismatched++;
        $display("[TB] FAIL tready_stall_hold %0d: got tvalid %b tdata %h arvalid %b araddr %h expected 1/a1/0/1",
                 i, tvalid4, tdata4, arvalid4, araddr4);
      end
    end
    tready4 = 1;
    step();
    compared++;
    if ({tvalid4, arvalid4, araddr4} !== {1'b0, 1'b1, 32'd2}) begin
      mismatched++;
      $display("[TB] FAIL tready_stall_release: got tvalid %b arvalid %b araddr %h expected 0/1/2",
               tvalid4, arvalid4, araddr4);
    end
    wait_done("tready_stall");
  endtask

  task automatic test_start_while_busy();
    int words, dones;
    bit pulsed;
    arready4 = 1; rvalid4 = 1; tready4 = 1;
    start4 = 1; step(); start4 = 0;
    words = 0; dones = 0; pulsed = 0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      if (tvalid4) words++;
      if (done4) dones++;
      if (tvalid4 && tdata4 == 32'hA2 && !pulsed) begin
        start4 = 1;
        pulsed = 1;
      end
      step();
      start4 = 0;
    end
    compared++;
    if (words != 4 || dones != 1 || !pulsed) begin
      mismatched++;
      $display("[TB] FAIL busy_start_ignored: got %0d words %0d dones pulsed %b expected 4/1/1",
               words, dones, pulsed);
    end
    compared++;
    if (busy4 !== 1'b0 || arvalid4 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL busy_no_queue: got busy %b arvalid %b expected 0/0", busy4, arvalid4);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit found, saw_done;
    arready4 = 1; rvalid4 = 1; tready4 = 1;
    start4 = 1; step(); start4 = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (rready4 && araddr4 == 32'd3) found = 1;
      else step();
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("[TB] FAIL midreset_reach: got no R for word 3, expected within 20 cycles");
    end
    #2 aresetn = 1'b0;
    #1;
    compared++;
    if ({busy4, done4, arvalid4, rready4, tvalid4, tlast4} !== 6'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset_ctrl: got %b expected 000000",
               {busy4, done4, arvalid4, rready4, tvalid4, tlast4});
    end
    compared++;
    if (araddr4 !== 32'd0 || tdata4 !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL midreset_data: got araddr %h tdata %h expected 0/0", araddr4, tdata4);
    end
    step();
    aresetn = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done4 || busy4 || arvalid4) saw_done = 1;
    end
    compared++;
    if (saw_done) begin
      mismatched++;
      $display("[TB] FAIL midreset_idle: got activity after release, expected idle with no done");
    end
    start4 = 1; step(); start4 = 0;
    compared++;
    if (arvalid4 !== 1'b1 || araddr4 !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL midreset_restart: got arvalid %b araddr %h expected 1/0", arvalid4, araddr4);
    end
    step();
    step();
    compared++;
    if (tvalid4 !== 1'b1 || tdata4 !== 32'hA0) begin
      mismatched++;
      $display("[TB] FAIL midreset_first_word: got tvalid %b tdata %h expected 1/a0", tvalid4, tdata4);
    end
    wait_done("midreset");
  endtask

  task automatic test_single_word();
    start1 = 1; step(); start1 = 0;
    compared++;
    if ({arvalid1, busy1, araddr1} !== {1'b1, 1'b1, 32'd0}) begin
      mismatched++;
      $display("[TB] FAIL single_ar: got arvalid %b busy %b araddr %h expected 1/1/0", arvalid1, busy1, araddr1);
    end
    step();
    compared++;
    if (rready1 !== 1'b1 || arvalid1 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL single_r: got rready %b arvalid %b expected 1/0", rready1, arvalid1);
    end
    step();
    compared++;
    if ({tvalid1, tlast1, tdata1} !== {1'b1, 1'b1, 32'hA0}) begin
      mismatched++;
      $display("[TB] FAIL single_out: got tvalid %b tlast %b tdata %h expected 1/1/a0", tvalid1, tlast1, tdata1);
    end
    step();
    compared++;
    if ({done1, busy1, tvalid1, tlast1} !== 4'b1100) begin
      mismatched++;
      $display("[TB] FAIL single_done: got %b expected 1100", {done1, busy1, tvalid1, tlast1});
    end
    step();
    compared++;
    if ({done1, busy1, arvalid1} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL single_idle: got %b expected 000", {done1, busy1, arvalid1});
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    $display("[TB] frame_read_master directed tests");
    test_reset();
    test_basic_frame();
    test_ar_stall();
    test_tready_stall();
    test_start_while_busy();
    test_reset_mid_frame();
    test_single_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
